// File: rtl/reset_pkg.sv
// Shared types and elaboration-time helpers for the reset sequencer.
package reset_pkg;

  typedef enum logic [2:0] {
    S_HOLD,
    S_SYNC,
    S_RELEASE,
    S_SOFT,
    S_DONE
  } rst_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit params_legal(input int unsigned num_out,
                                      input int unsigned sync_stages,
                                      input int unsigned stage_delay,
                                      input int unsigned min_pulse);
    return (num_out >= 1) && (num_out <= 32) && (sync_stages >= 2) &&
           (stage_delay >= 1) && (min_pulse >= 1);
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Asynchronous-clear synchroniser that shifts a 1 in once reset is released.
module rst_sync_chain #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_out
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Turns one async active-low reset into NUM_OUT ordered, synchronously released resets,
// with a soft-reset request that forces a minimum low pulse before re-sequencing.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int unsigned NUM_OUT     = 4,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned STAGE_DELAY = 16,
  parameter int unsigned MIN_PULSE   = 8
) (
  input  logic               clk,
  input  logic               resn_in,
  input  logic               soft_rst_req,
  output logic [NUM_OUT-1:0] resn_out,
  output logic               rst_done
);

  localparam int unsigned CW = $clog2(max_u(STAGE_DELAY, MIN_PULSE)) + 1;
  localparam int unsigned IW = $clog2(NUM_OUT) + 1;

  localparam logic [CW-1:0] StageLast = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] PulseLast = CW'(MIN_PULSE - 1);
  localparam logic [IW-1:0] IdxLast   = IW'(NUM_OUT - 1);

  if (!params_legal(NUM_OUT, SYNC_STAGES, STAGE_DELAY, MIN_PULSE)) begin : g_bad_params
    $error("reset_sequencer: illegal parameter combination");
  end

  rst_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NUM_OUT-1:0] resn_q, resn_d;
  logic              done_q, done_d;
  logic              sync_out;

  rst_sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (resn_in),
    .sync_out(sync_out)
  );

  always_ff @(posedge clk or negedge resn_in) begin
    if (!resn_in) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      resn_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      resn_q  <= resn_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    resn_d  = resn_q;
    done_d  = done_q;
    unique case (state_q)
      S_HOLD: begin
        state_d = S_SYNC;
        cnt_d   = '0;
        idx_d   = '0;
      end
      S_SYNC: begin
        if (sync_out) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_RELEASE: begin
        // A soft request wins over a release falling on the same edge.
        if (soft_rst_req) begin
          state_d = S_SOFT;
          cnt_d   = '0;
          idx_d   = '0;
          resn_d  = '0;
          done_d  = 1'b0;
        end else if (cnt_q == StageLast) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          for (int i = 0; i < NUM_OUT; i++) begin
            if (idx_q == IW'(i)) resn_d[i] = 1'b1;
          end
          if (idx_q == IdxLast) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SOFT: begin
        if (cnt_q == PulseLast) begin
          if (!soft_rst_req) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (soft_rst_req) begin
          state_d = S_SOFT;
          cnt_d   = '0;
          idx_d   = '0;
          resn_d  = '0;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

  assign resn_out = resn_q;
  assign rst_done = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a release-time model feeds a per-edge scoreboard.
module tb_reset_sequencer;

  localparam int SS = 3;
  localparam int SD = 16;
  localparam int MP = 8;

  logic       clk = 1'b0;
  logic       resn_in, soft_rst_req;
  logic [3:0] resn_out;
  logic       rst_done;
  logic       resn_s, soft_s;
  logic [0:0] out_s;
  logic       done_s;

  int errors = 0;
  int checks = 0;
  int ecount = 0;
  int rel    = -1;  // edge at which the main DUT enters S_RELEASE; -1 = held low
  int rel_s  = -1;

  typedef struct {
    int         edge_no;
    logic [3:0] out;
    logic       done;
    logic       out_s;
    logic       done_s;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  reset_sequencer u_dut (
    .clk         (clk),
    .resn_in     (resn_in),
    .soft_rst_req(soft_rst_req),
    .resn_out    (resn_out),
    .rst_done    (rst_done)
  );

  reset_sequencer #(
    .NUM_OUT    (1),
    .SYNC_STAGES(2),
    .STAGE_DELAY(1),
    .MIN_PULSE  (1)
  ) u_small (
    .clk         (clk),
    .resn_in     (resn_s),
    .soft_rst_req(soft_s),
    .resn_out    (out_s),
    .rst_done    (done_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int e);
    exp_t x;
    x.edge_no = e;
    for (int i = 0; i < 4; i++) begin
      x.out[i] = (rel >= 0) && (e >= rel + (i + 1) * SD);
    end
    x.done   = &x.out;
    x.out_s  = (rel_s >= 0) && (e >= rel_s + 1);
    x.done_s = x.out_s;
    return x;
  endfunction

  // Push the expectation for the coming edge, clock it, then pop and compare.
  task automatic step();
    exp_t x;
    sb.push_back(model(ecount + 1));
    @(posedge clk);
    #1;
    ecount++;
    x = sb.pop_front();
    check($sformatf("edge_no@%0d", ecount), 32'(x.edge_no), 32'(ecount));
    check($sformatf("resn_out@%0d", ecount), 32'(resn_out), 32'(x.out));
    check($sformatf("rst_done@%0d", ecount), 32'(rst_done), 32'(x.done));
    check($sformatf("small_out@%0d", ecount), 32'(out_s), 32'(x.out_s));
    check($sformatf("small_done@%0d", ecount), 32'(done_s), 32'(x.done_s));
  endtask

  task automatic run_to(input int n);
    while (ecount < n) step();
  endtask

  initial begin
    resn_in      = 1'b0;
    soft_rst_req = 1'b0;
    resn_s       = 1'b0;
    soft_s       = 1'b0;
    #2;
    check("reset_out", 32'(resn_out), 32'h0);
    check("reset_done", 32'(rst_done), 32'h0);
    check("reset_small", 32'(out_s), 32'h0);
    @(posedge clk);
    #1;

    // Scenario 1: release at edge 1; entry to S_RELEASE at SS+1.
    resn_in = 1'b1;
    ecount  = 0;
    rel     = SS + 1;
    run_to(40);

    // Scenario 2: async reset mid-clock, visible before the next edge.
    #3 resn_in = 1'b0;
    rel = -1;
    #1;
    check("async_out", 32'(resn_out), 32'h0);
    check("async_done", 32'(rst_done), 32'h0);
    step();
    step();
    resn_in = 1'b1;
    ecount  = 0;
    rel     = SS + 1;
    run_to(99);

    // Scenario 3: single-cycle soft request at edge 100 in S_DONE.
    soft_rst_req = 1'b1;
    rel          = 100 + MP;
    step();
    soft_rst_req = 1'b0;
    run_to(199);

    // Scenario 4: request held for 20 cycles from edge 200.
    soft_rst_req = 1'b1;
    rel          = 200 + 20;
    repeat (20) step();
    soft_rst_req = 1'b0;
    run_to(239);

    // Scenario 5: request during S_RELEASE with only bit 0 released.
    check("partial_release", 32'(resn_out), 32'h1);
    soft_rst_req = 1'b1;
    rel          = 240 + MP;
    step();
    soft_rst_req = 1'b0;
    run_to(320);

    // Scenario 6: minimal configuration; soft request in S_HOLD/S_SYNC is ignored.
    resn_in = 1'b0;
    rel     = -1;
    #1;
    check("main_held", 32'(resn_out), 32'h0);
    resn_s = 1'b1;
    soft_s = 1'b1;
    ecount = 0;
    rel_s  = 2 + 1;
    repeat (3) step();
    soft_s = 1'b0;
    run_to(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
